dmem_arbiter: RTL and testbench

- Two-requester round-robin arbiter and access sequencer in front of the single-port data memory (8-bit data, 4-bit address).
- Requester 0 is the core load/store unit. Requester 1 is the debug/print/DMA path.
- Registers the winning request, drives the memory's enable/write-enable/address/data for exactly one cycle, captures read data, and returns a one-cycle Ack with held read data.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/dmem_arbiter_rr_arb2.sv | 31 +++
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   DEF_ADDR_W / DEF_DATA_W : default memory address / data widths
//   state_t                 : access sequencer states
//   req_id_t, REQ_CORE/AUX  : requester identifiers (0 = load/store unit, 1 = debug/DMA)
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_CORE = 1'b0;
  localparam req_id_t REQ_AUX  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//   Req*/WE*/Addr*/DataIn* : requester commands (valid at the IDLE sampling edge)
//   Ack*/DataOut*          : one-cycle completion pulse and held read data
//   Mem_*                  : single-port memory control and data
//   Busy                   : arbiter is not idle
// Modport slave is the arbiter's view; master is the requesters'/memory's view.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              Req0;
  logic              WE0;
  logic [ADDR_W-1:0] Addr0;
  logic [DATA_W-1:0] DataIn0;
  logic              Ack0;
  logic [DATA_W-1:0] DataOut0;

  logic              Req1;
  logic              WE1;
  logic [ADDR_W-1:0] Addr1;
  logic [DATA_W-1:0] DataIn1;
  logic              Ack1;
  logic [DATA_W-1:0] DataOut1;

  logic              Mem_E;
  logic              Mem_WE;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_DataIn;
  logic [DATA_W-1:0] Mem_DataOut;
  logic              Busy;

  modport slave (
    input  Req0, WE0, Addr0, DataIn0,
    input  Req1, WE1, Addr1, DataIn1,
    output Ack0, DataOut0, Ack1, DataOut1,
    output Mem_E, Mem_WE, Mem_Addr, Mem_DataIn, Busy,
    input  Mem_DataOut
  );

  modport master (
    output Req0, WE0, Addr0, DataIn0,
    output Req1, WE1, Addr1, DataIn1,
    input  Ack0, DataOut0, Ack1, DataOut1,
    input  Mem_E, Mem_WE, Mem_Addr, Mem_DataIn, Busy,
    output Mem_DataOut
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker.
//   req[1:0]  : request levels
//   advance   : commit the current pick as the new last grant
//   gnt_valid : at least one request present
//   gnt_id    : chosen requester; on a tie, the one not granted last
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_valid,
  output req_id_t    gnt_id
);

  req_id_t last_grant_q;

  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) gnt_id = ~last_grant_q;
    else              gnt_id = req[1] ? REQ_AUX : REQ_CORE;
  end

  // Reset to REQ_AUX so the load/store unit wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       last_grant_q <= REQ_AUX;
    else if (advance && gnt_valid) last_grant_q <= gnt_id;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the single-port data memory.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester commands/acks and memory control (see dmem_arbiter_if)
// Each granted request runs IDLE -> ACCESS (one memory cycle) -> ACK (one-cycle
// pulse); every output is a flop so nothing combinational reaches the memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
)(
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  state_t            state_q,    state_d;
  req_id_t           gnt_q,      gnt_d;
  logic              mem_e_q,    mem_e_d;
  logic              mem_we_q,   mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q,  mem_din_d;
  logic [DATA_W-1:0] dout0_q,    dout0_d;
  logic [DATA_W-1:0] dout1_q,    dout1_d;
  logic              ack0_q,     ack0_d;
  logic              ack1_q,     ack1_d;
  logic              busy_q,     busy_d;

  logic    gnt_valid;
  req_id_t gnt_id;

  // The picker only commits while the sequencer is idle, so requests raised
  // during ACCESS/ACK simply wait for the next IDLE sample.
  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .req       ({bus.Req1, bus.Req0}),
    .advance   (state_q == IDLE),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d    = state_q;
    gnt_d      = gnt_q;
    mem_e_d    = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    dout0_d    = dout0_q;
    dout1_d    = dout1_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d    = ACCESS;
          gnt_d      = gnt_id;
          mem_e_d    = 1'b1;
          mem_we_d   = (gnt_id == REQ_AUX) ? bus.WE1     : bus.WE0;
          mem_addr_d = (gnt_id == REQ_AUX) ? bus.Addr1   : bus.Addr0;
          mem_din_d  = (gnt_id == REQ_AUX) ? bus.DataIn1 : bus.DataIn0;
        end
      end
      ACCESS: begin
        // Read data is captured on the same edge a write would commit.
        if (!mem_we_q) begin
          if (gnt_q == REQ_AUX) dout1_d = bus.Mem_DataOut;
          else                  dout0_d = bus.Mem_DataOut;
        end
        ack0_d  = (gnt_q == REQ_CORE);
        ack1_d  = (gnt_q == REQ_AUX);
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the asynchronous reset drops Mem_E at once, aborting an in-flight
    // write before its commit edge and suppressing any pending Ack.
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= REQ_CORE;
      mem_e_q    <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      dout0_q    <= '0;
      dout1_q    <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      mem_e_q    <= mem_e_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      dout0_q    <= dout0_d;
      dout1_q    <= dout1_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.Mem_E      = mem_e_q;
  assign bus.Mem_WE     = mem_we_q;
  assign bus.Mem_Addr   = mem_addr_q;
  assign bus.Mem_DataIn = mem_din_q;
  assign bus.DataOut0   = dout0_q;
  assign bus.DataOut1   = dout1_q;
  assign bus.Ack0       = ack0_q;
  assign bus.Ack1       = ack1_q;
  assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a 16x8 memory model, a scoreboard of
// expected Acks (requester id + DataOut value) popped when an Ack appears.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  typedef struct {
    logic       id;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_errors;

  exp_t       sb_q[$];
  logic [7:0] ref_mem [16];
  logic [7:0] exp_dout [2];
  logic [7:0] mem [16] = '{default: 8'h00};
  int         last_ack_cyc;
  int         prev_ack_cyc;

  dmem_arbiter_if bus_if ();

  dmem_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Memory model: combinational read, write commits on the edge closing ACCESS.
  assign bus_if.Mem_DataOut = mem[bus_if.Mem_Addr];
  always @(posedge clk) begin
    if (bus_if.Mem_E && bus_if.Mem_WE) mem[bus_if.Mem_Addr] <= bus_if.Mem_DataIn;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Ack monitor: every Ack must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!rst && (bus_if.Ack0 || bus_if.Ack1)) begin
      prev_ack_cyc = last_ack_cyc;
      last_ack_cyc = cyc;
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {30'd0, bus_if.Ack1, bus_if.Ack0}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ack_id", {30'd0, bus_if.Ack1, bus_if.Ack0}, e.id ? 32'd2 : 32'd1);
        check("dataout", e.id ? {24'd0, bus_if.DataOut1} : {24'd0, bus_if.DataOut0},
              {24'd0, e.data});
      end
    end
  end

  task automatic drive(input logic id, input logic req, input logic we,
                       input logic [3:0] addr, input logic [7:0] data);
    if (id) begin
      bus_if.Req1 = req; bus_if.WE1 = we; bus_if.Addr1 = addr; bus_if.DataIn1 = data;
    end else begin
      bus_if.Req0 = req; bus_if.WE0 = we; bus_if.Addr0 = addr; bus_if.DataIn0 = data;
    end
  endtask

  // Records the expected outcome of a transaction in issue order.
  task automatic expect_txn(input logic id, input logic we,
                            input logic [3:0] addr, input logic [7:0] data);
    exp_t e;
    if (we) ref_mem[addr] = data;
    else    exp_dout[id]  = ref_mem[addr];
    e.id   = id;
    e.data = exp_dout[id];
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb_q.size(), 32'd0);
    sb_q.delete();
  endtask

  // One isolated transaction; starts from a negedge while the arbiter is idle.
  task automatic do_single(input logic id, input logic we,
                           input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    drive(id, 1'b1, we, addr, data);
    expect_txn(id, we, addr, data);
    @(posedge clk); #1;
    drive(id, 1'b0, 1'b0, 4'h0, 8'h00);
    check("access_mem_e", bus_if.Mem_E, 1'b1);
    check("access_mem_we", bus_if.Mem_WE, we);
    check("access_addr", bus_if.Mem_Addr, addr);
    if (we) check("access_din", bus_if.Mem_DataIn, data);
    @(posedge clk); #1;
    check("ack_latency", id ? bus_if.Ack1 : bus_if.Ack0, 1'b1);
    check("mem_e_one_cycle", bus_if.Mem_E, 1'b0);
    wait_drain("single_drain");
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    last_ack_cyc = 0; prev_ack_cyc = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    exp_dout[0] = 8'h00; exp_dout[1] = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    rst = 1'b1;

    // 1: reset state, then 10 idle cycles with everything quiet.
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus_if.Ack0, bus_if.Ack1, bus_if.DataOut0, bus_if.DataOut1,
          bus_if.Mem_E, bus_if.Mem_WE, bus_if.Mem_Addr, bus_if.Mem_DataIn, bus_if.Busy}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_quiet", {bus_if.Ack0, bus_if.Ack1, bus_if.Mem_E, bus_if.Mem_WE, bus_if.Busy},
            32'd0);
    end

    // 2: requester 0 write then read back.
    do_single(1'b0, 1'b1, 4'h3, 8'hA5);
    do_single(1'b0, 1'b0, 4'h3, 8'h00);
    check("dout0_after_read", bus_if.DataOut0, 8'hA5);

    // 6: requester 1 read of address 0, then a write must not disturb DataOut1.
    do_single(1'b1, 1'b1, 4'h0, 8'h77);
    do_single(1'b1, 1'b0, 4'h0, 8'h00);
    do_single(1'b1, 1'b1, 4'hF, 8'h5A);
    check("dout1_held_after_write", bus_if.DataOut1, 8'h77);

    // Preload for the tie test; requester 1 is granted last, so 0 wins next.
    do_single(1'b1, 1'b1, 4'h1, 8'h11);
    do_single(1'b1, 1'b1, 4'h2, 8'h22);

    // 3: simultaneous reads, requester 0 first, Acks three cycles apart.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 4'h1, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 4'h2, 8'h00);
    expect_txn(1'b0, 1'b0, 4'h1, 8'h00);
    expect_txn(1'b1, 1'b0, 4'h2, 8'h00);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    check("tie_first_addr", bus_if.Mem_Addr, 4'h1);
    repeat (3) @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    check("tie_second_addr", bus_if.Mem_Addr, 4'h2);
    wait_drain("tie_drain");
    check("ack_spacing", last_ack_cyc - prev_ack_cyc, 32'd3);
    check("tie_dout0", bus_if.DataOut0, 8'h11);
    check("tie_dout1", bus_if.DataOut1, 8'h22);

    // 4: both requests held 12 cycles, all writes: strict alternation.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 4'h5, 8'h50);
    drive(1'b1, 1'b1, 1'b1, 4'h6, 8'h60);
    for (int t = 0; t < 4; t++) expect_txn(t[0], 1'b1, t[0] ? 4'h6 : 4'h5, t[0] ? 8'h60 : 8'h50);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check("rr_busy", bus_if.Busy, (k % 3) != 2);
      if ((k % 3) == 0) check("rr_order", bus_if.Mem_Addr, ((k / 3) % 2) ? 4'h6 : 4'h5);
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    wait_drain("rr_drain");

    // 5: reset in mid-ACCESS of a write to the top address aborts it.
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 4'hF, 8'hFF);
    @(posedge clk); #1;
    check("abort_mem_e_before", bus_if.Mem_E, 1'b1);
    #2 rst = 1'b1;
    #1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    check("abort_mem_e_dropped", bus_if.Mem_E, 1'b0);
    check("abort_outputs", {bus_if.Ack0, bus_if.Ack1, bus_if.Busy,
          bus_if.DataOut0, bus_if.DataOut1}, 32'd0);
    exp_dout[0] = 8'h00; exp_dout[1] = 8'h00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_ack_late", {bus_if.Ack0, bus_if.Ack1}, 2'b00);
    do_single(1'b0, 1'b0, 4'hF, 8'h00);
    check("abort_old_value", bus_if.DataOut0, 8'h5A);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
